vx_warp_ibuffer: RTL

Per-issue-slice instruction buffer sitting between decode and the scoreboard stage. Accepts one decoded instruction per cycle tagged with its issue-local warp index and steers it into a dedicated per-warp FIFO. Presents each FIFO head on its own valid/ready channel to the scoreboard's per-warp inputs. Returns a registered per-warp pop pulse to the warp scheduler for fetch-credit accounting.

---
 rtl/vx_warp_ibuffer_pkg.sv | 15 +
 rtl/vx_ibuf_fifo.sv | 62 ++++++
 rtl/vx_warp_ibuffer.sv | 98 +++++++++
 3 files changed

// File: rtl/vx_warp_ibuffer_pkg.sv
// Shared payload type and slice sizing for the per-warp instruction buffer.
package vx_warp_ibuffer_pkg;

    localparam int unsigned PER_ISSUE_WARPS = 4;
    localparam int unsigned ISSUE_WIS_W     = (PER_ISSUE_WARPS > 1) ? $clog2(PER_ISSUE_WARPS) : 1;
    localparam int unsigned PERF_CTR_BITS   = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op_type;
        logic [4:0]  rd;
        logic        wb;
    } ibuffer_t;

endpackage

// File: rtl/vx_ibuf_fifo.sv
// Single-warp instruction FIFO; the caller must never push while full.
module vx_ibuf_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DATAW = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= data_in;
        end
    end

    assign data_out = mem_q[rptr_q];
    assign count    = count_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/vx_warp_ibuffer.sv
// Per-issue-slice instruction buffer: steers decoded instructions into per-warp FIFOs.
// Optional stall counter output enabled by defining IBUF_PERF_EN.
module vx_warp_ibuffer #(
    parameter int unsigned PER_ISSUE_WARPS = vx_warp_ibuffer_pkg::PER_ISSUE_WARPS,
    parameter int unsigned IBUF_SIZE       = 4,
    parameter int unsigned DATAW           = $bits(vx_warp_ibuffer_pkg::ibuffer_t)
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        decode_valid,
    input  logic [vx_warp_ibuffer_pkg::ISSUE_WIS_W-1:0] decode_wis,
    input  logic [DATAW-1:0]                            decode_data,
    output logic                                        decode_ready,
    output logic [PER_ISSUE_WARPS-1:0]                  ibuf_valid,
    output logic [PER_ISSUE_WARPS-1:0][DATAW-1:0]       ibuf_data,
    input  logic [PER_ISSUE_WARPS-1:0]                  ibuf_ready,
    output logic [PER_ISSUE_WARPS-1:0]                  ibuf_pop,
`ifdef IBUF_PERF_EN
    output logic [vx_warp_ibuffer_pkg::PERF_CTR_BITS-1:0] perf_ibuf_stalls,
`endif
    output logic [PER_ISSUE_WARPS-1:0]                  ibuf_empty
);

    import vx_warp_ibuffer_pkg::*;

    localparam int unsigned CNT_W = $clog2(IBUF_SIZE) + 1;

    logic [PER_ISSUE_WARPS-1:0] push;
    logic [PER_ISSUE_WARPS-1:0] pop;
    logic [PER_ISSUE_WARPS-1:0] full;
    logic [PER_ISSUE_WARPS-1:0] pop_q;
    logic [CNT_W-1:0]           count [PER_ISSUE_WARPS];

    // Out-of-range indices match no warp, so ready stays low for them.
    always_comb begin
        decode_ready = 1'b0;
        for (int unsigned w = 0; w < PER_ISSUE_WARPS; w++) begin
            if (decode_wis == ISSUE_WIS_W'(w)) begin
                decode_ready = ~full[w];
            end
        end
    end

    for (genvar w = 0; w < PER_ISSUE_WARPS; w++) begin : g_warp
        assign push[w]       = decode_valid && decode_ready && (decode_wis == ISSUE_WIS_W'(w));
        assign pop[w]        = ibuf_valid[w] && ibuf_ready[w];
        assign ibuf_valid[w] = (count[w] != '0);

        vx_ibuf_fifo #(
            .DEPTH (IBUF_SIZE),
            .DATAW (DATAW)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push[w]),
            .pop      (pop[w]),
            .data_in  (decode_data),
            .data_out (ibuf_data[w]),
            .count    (count[w]),
            .full     (full[w]),
            .empty    (ibuf_empty[w])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_q <= '0;
        end else begin
            pop_q <= pop;
        end
    end

    assign ibuf_pop = pop_q;

`ifdef IBUF_PERF_EN
    logic [PERF_CTR_BITS-1:0] stalls_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stalls_q <= '0;
        end else if (decode_valid && !decode_ready) begin
            stalls_q <= stalls_q + 1'b1;
        end
    end

    assign perf_ibuf_stalls = stalls_q;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && decode_valid) begin
            assert (32'(decode_wis) < PER_ISSUE_WARPS)
            else $error("vx_warp_ibuffer: decode_wis %0d out of range", decode_wis);
        end
    end
`endif

endmodule
